// File: rtl/udp_rx_parser.sv
// ---------------------------------------------------------------------------
// udp_rx_parser
//
// Receive-side UDP layer. Consumes the IPv4 RX payload byte stream, strips
// and decodes the 8-byte UDP header, and presents the header fields plus a
// payload byte stream to user logic. Trailing IP padding beyond the UDP
// length is dropped; a datagram that ends early is flagged with udp_rx_err.
//
// Parameters:
//   PORT_FILTER_EN      - when 1, datagrams whose destination port differs
//                         from udp_rx_port_filter are dropped silently
//
// Ports:
//   clk                 - system clock, rising edge
//   reset               - asynchronous reset, active low
//   ip_rx_start         - one-cycle pulse, new IPv4 datagram (header inputs valid)
//   ip_rx_protocol      - IPv4 protocol field (UDP = 0x11)
//   ip_rx_src_ip        - IPv4 source address
//   ip_rx_is_valid      - IPv4 header passed its checks
//   ip_rx_data_in       - IPv4 payload byte
//   ip_rx_data_in_valid - byte qualifier
//   ip_rx_data_in_last  - final payload byte of the datagram (with valid)
//   udp_rx_port_filter  - accepted destination port when filtering
//   udp_rx_start        - one-cycle pulse, header outputs valid until next start
//   udp_rx_src_ip       - latched source IP
//   udp_rx_src_port     - UDP source port
//   udp_rx_dst_port     - UDP destination port
//   udp_rx_data_length  - payload byte count (UDP length - 8)
//   udp_rx_data_out     - payload byte
//   udp_rx_data_out_valid - payload byte qualifier
//   udp_rx_data_out_last  - final payload byte
//   udp_rx_err          - one-cycle pulse on a malformed datagram
// ---------------------------------------------------------------------------
module udp_rx_parser #(
    parameter bit PORT_FILTER_EN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ip_rx_start,
    input  logic [7:0]  ip_rx_protocol,
    input  logic [31:0] ip_rx_src_ip,
    input  logic        ip_rx_is_valid,
    input  logic [7:0]  ip_rx_data_in,
    input  logic        ip_rx_data_in_valid,
    input  logic        ip_rx_data_in_last,
    input  logic [15:0] udp_rx_port_filter,
    output logic        udp_rx_start,
    output logic [31:0] udp_rx_src_ip,
    output logic [15:0] udp_rx_src_port,
    output logic [15:0] udp_rx_dst_port,
    output logic [15:0] udp_rx_data_length,
    output logic [7:0]  udp_rx_data_out,
    output logic        udp_rx_data_out_valid,
    output logic        udp_rx_data_out_last,
    output logic        udp_rx_err
);

    localparam logic [7:0]  PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] dst_port_q, dst_port_d;
    logic [15:0] length_q, length_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic        err_pending_q, err_pending_d;

    logic        start_d;
    logic [31:0] out_src_ip_d;
    logic [15:0] out_src_port_d;
    logic [15:0] out_dst_port_d;
    logic [15:0] out_length_d;
    logic [7:0]  data_d;
    logic        valid_d;
    logic        last_d;
    logic        err_d;

    // Header fields are collected in private registers and only copied to the
    // outputs on the start pulse, so the user-visible fields stay stable from
    // one udp_rx_start to the next even while a later header is being parsed.
    // err_pending covers the one case where an error must follow a start: the
    // header announced payload but the IP datagram ended on header byte 7.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        remaining_d    = remaining_q;
        src_port_d     = src_port_q;
        dst_port_d     = dst_port_q;
        length_d       = length_q;
        src_ip_d       = src_ip_q;
        err_pending_d  = 1'b0;

        start_d        = 1'b0;
        out_src_ip_d   = udp_rx_src_ip;
        out_src_port_d = udp_rx_src_port;
        out_dst_port_d = udp_rx_dst_port;
        out_length_d   = udp_rx_data_length;
        data_d         = udp_rx_data_out;
        valid_d        = 1'b0;
        last_d         = 1'b0;
        err_d          = err_pending_q;

        if (ip_rx_start) begin
            // A new datagram always wins; one cut off mid-header or mid-payload
            // is reported as an error and never gets an out_last.
            if (state_q == HDR || state_q == DATA) begin
                err_d = 1'b1;
            end
            src_ip_d   = ip_rx_src_ip;
            byte_cnt_d = 3'd0;
            if (ip_rx_protocol == PROTO_UDP && ip_rx_is_valid) begin
                state_d = HDR;
            end else begin
                state_d = DISCARD;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end

                HDR: begin
                    if (ip_rx_data_in_valid) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        case (byte_cnt_q)
                            3'd0:    src_port_d[15:8] = ip_rx_data_in;
                            3'd1:    src_port_d[7:0]  = ip_rx_data_in;
                            3'd2:    dst_port_d[15:8] = ip_rx_data_in;
                            3'd3:    dst_port_d[7:0]  = ip_rx_data_in;
                            3'd4:    length_d[15:8]   = ip_rx_data_in;
                            3'd5:    length_d[7:0]    = ip_rx_data_in;
                            default: length_d         = length_q;
                        endcase

                        if (byte_cnt_q != 3'd7) begin
                            if (ip_rx_data_in_last) begin
                                err_d   = 1'b1;
                                state_d = IDLE;
                            end
                        end else if (length_q < UDP_HDR_LEN) begin
                            err_d   = 1'b1;
                            state_d = ip_rx_data_in_last ? IDLE : DISCARD;
                        end else if (PORT_FILTER_EN && (dst_port_q != udp_rx_port_filter)) begin
                            state_d = ip_rx_data_in_last ? IDLE : DISCARD;
                        end else begin
                            start_d        = 1'b1;
                            out_src_ip_d   = src_ip_q;
                            out_src_port_d = src_port_q;
                            out_dst_port_d = dst_port_q;
                            out_length_d   = length_q - UDP_HDR_LEN;
                            if (length_q == UDP_HDR_LEN) begin
                                state_d = ip_rx_data_in_last ? IDLE : DISCARD;
                            end else if (ip_rx_data_in_last) begin
                                err_pending_d = 1'b1;
                                state_d       = IDLE;
                            end else begin
                                remaining_d = length_q - UDP_HDR_LEN;
                                state_d     = DATA;
                            end
                        end
                    end
                end

                DATA: begin
                    if (ip_rx_data_in_valid) begin
                        data_d      = ip_rx_data_in;
                        valid_d     = 1'b1;
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            // Anything the IP layer sends after this is padding.
                            last_d  = 1'b1;
                            state_d = ip_rx_data_in_last ? IDLE : DISCARD;
                        end else if (ip_rx_data_in_last) begin
                            last_d  = 1'b1;
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end

                DISCARD: begin
                    if (ip_rx_data_in_valid && ip_rx_data_in_last) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt_q            <= 3'd0;
            remaining_q           <= 16'd0;
            src_port_q            <= 16'd0;
            dst_port_q            <= 16'd0;
            length_q              <= 16'd0;
            src_ip_q              <= 32'd0;
            err_pending_q         <= 1'b0;
            udp_rx_start          <= 1'b0;
            udp_rx_src_ip         <= 32'd0;
            udp_rx_src_port       <= 16'd0;
            udp_rx_dst_port       <= 16'd0;
            udp_rx_data_length    <= 16'd0;
            udp_rx_data_out       <= 8'd0;
            udp_rx_data_out_valid <= 1'b0;
            udp_rx_data_out_last  <= 1'b0;
            udp_rx_err            <= 1'b0;
        end else begin
            byte_cnt_q            <= byte_cnt_d;
            remaining_q           <= remaining_d;
            src_port_q            <= src_port_d;
            dst_port_q            <= dst_port_d;
            length_q              <= length_d;
            src_ip_q              <= src_ip_d;
            err_pending_q         <= err_pending_d;
            udp_rx_start          <= start_d;
            udp_rx_src_ip         <= out_src_ip_d;
            udp_rx_src_port       <= out_src_port_d;
            udp_rx_dst_port       <= out_dst_port_d;
            udp_rx_data_length    <= out_length_d;
            udp_rx_data_out       <= data_d;
            udp_rx_data_out_valid <= valid_d;
            udp_rx_data_out_last  <= last_d;
            udp_rx_err            <= err_d;
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// ---------------------------------------------------------------------------
// tb_udp_rx_parser
//
// Drives directed and randomized IPv4 payload streams into udp_rx_parser
// (port filter enabled, filter 0x0050) and compares what comes out against
// a datagram-level reference model computed from the UDP header rules.
// ---------------------------------------------------------------------------
module tb_udp_rx_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic        ip_rx_start;
    logic [7:0]  ip_rx_protocol;
    logic [31:0] ip_rx_src_ip;
    logic        ip_rx_is_valid;
    logic [7:0]  ip_rx_data_in;
    logic        ip_rx_data_in_valid;
    logic        ip_rx_data_in_last;
    logic [15:0] udp_rx_port_filter;
    logic        udp_rx_start;
    logic [31:0] udp_rx_src_ip;
    logic [15:0] udp_rx_src_port;
    logic [15:0] udp_rx_dst_port;
    logic [15:0] udp_rx_data_length;
    logic [7:0]  udp_rx_data_out;
    logic        udp_rx_data_out_valid;
    logic        udp_rx_data_out_last;
    logic        udp_rx_err;

    always #5 clk = ~clk;

    udp_rx_parser #(.PORT_FILTER_EN(1'b1)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ip_rx_start           (ip_rx_start),
        .ip_rx_protocol        (ip_rx_protocol),
        .ip_rx_src_ip          (ip_rx_src_ip),
        .ip_rx_is_valid        (ip_rx_is_valid),
        .ip_rx_data_in         (ip_rx_data_in),
        .ip_rx_data_in_valid   (ip_rx_data_in_valid),
        .ip_rx_data_in_last    (ip_rx_data_in_last),
        .udp_rx_port_filter    (udp_rx_port_filter),
        .udp_rx_start          (udp_rx_start),
        .udp_rx_src_ip         (udp_rx_src_ip),
        .udp_rx_src_port       (udp_rx_src_port),
        .udp_rx_dst_port       (udp_rx_dst_port),
        .udp_rx_data_length    (udp_rx_data_length),
        .udp_rx_data_out       (udp_rx_data_out),
        .udp_rx_data_out_valid (udp_rx_data_out_valid),
        .udp_rx_data_out_last  (udp_rx_data_out_last),
        .udp_rx_err            (udp_rx_err)
    );

    int checks   = 0;
    int failures = 0;

    // Cycle counter advanced on every rising edge; used to timestamp both the
    // bytes the driver presents and the outputs the monitor sees.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmit side: bytes of the current datagram and the cycle each was presented.
    logic [7:0] tx_bytes[$];
    int         tx_cycs[$];

    // Monitor: cumulative record of everything the DUT emits.
    int          mon_starts = 0;
    int          mon_errs = 0;
    int          mon_overlap = 0;
    int          last_start_cyc = 0;
    logic [31:0] mon_src_ip = '0;
    logic [15:0] mon_src_port = '0;
    logic [15:0] mon_dst_port = '0;
    logic [15:0] mon_len = '0;
    logic [7:0]  mon_bytes[$];
    logic        mon_lasts[$];
    int          mon_cycs[$];

    // Outputs are registered, so sampling on the falling edge is race free.
    always @(negedge clk) begin
        if (reset) begin
            if (udp_rx_start) begin
                mon_starts++;
                last_start_cyc = cyc;
                mon_src_ip   = udp_rx_src_ip;
                mon_src_port = udp_rx_src_port;
                mon_dst_port = udp_rx_dst_port;
                mon_len      = udp_rx_data_length;
            end
            if (udp_rx_err) mon_errs++;
            if (udp_rx_start && (udp_rx_err || udp_rx_data_out_valid)) mon_overlap++;
            if (udp_rx_data_out_valid) begin
                mon_bytes.push_back(udp_rx_data_out);
                mon_lasts.push_back(udp_rx_data_out_last);
                mon_cycs.push_back(cyc);
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_hdr(input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] len, input logic [15:0] cs);
        tx_bytes.push_back(sp[15:8]);
        tx_bytes.push_back(sp[7:0]);
        tx_bytes.push_back(dp[15:8]);
        tx_bytes.push_back(dp[7:0]);
        tx_bytes.push_back(len[15:8]);
        tx_bytes.push_back(len[7:0]);
        tx_bytes.push_back(cs[15:8]);
        tx_bytes.push_back(cs[7:0]);
    endtask

    // Sends one ip_rx_start followed by tx_bytes, with optional random idle
    // cycles carrying junk data, then lets the pipeline drain.
    task automatic apply_stimulus(input logic [7:0] proto, input logic ip_ok,
                                  input logic [31:0] ip, input bit send_last, input int gap_pct);
        @(negedge clk);
        ip_rx_start    = 1'b1;
        ip_rx_protocol = proto;
        ip_rx_src_ip   = ip;
        ip_rx_is_valid = ip_ok;
        @(negedge clk);
        ip_rx_start = 1'b0;
        tx_cycs.delete();
        for (int i = 0; i < tx_bytes.size(); i++) begin
            if ($urandom_range(99) < gap_pct) begin
                ip_rx_data_in      = 8'($urandom);
                ip_rx_data_in_last = 1'($urandom);
                @(negedge clk);
            end
            ip_rx_data_in_valid = 1'b1;
            ip_rx_data_in       = tx_bytes[i];
            ip_rx_data_in_last  = send_last && (i == tx_bytes.size() - 1);
            tx_cycs.push_back(cyc);
            @(negedge clk);
            ip_rx_data_in_valid = 1'b0;
            ip_rx_data_in_last  = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    // Reference model: what one complete datagram must produce, derived from
    // the header contents and how many bytes the IP layer actually delivered.
    task automatic check_datagram(input string tag, input logic [7:0] proto, input logic ip_ok,
                                  input logic [31:0] ip, input int base_s, input int base_e,
                                  input int base_b, input int extra_err);
        int n, pay, avail, fwd, exp_start, exp_err;
        logic [15:0] sp, dp, len;
        n = tx_bytes.size();
        exp_start = 0;
        exp_err = extra_err;
        fwd = 0;
        sp = '0;
        dp = '0;
        len = '0;
        if (proto == 8'h11 && ip_ok) begin
            if (n < 8) begin
                exp_err++;
            end else begin
                sp  = {tx_bytes[0], tx_bytes[1]};
                dp  = {tx_bytes[2], tx_bytes[3]};
                len = {tx_bytes[4], tx_bytes[5]};
                if (len < 16'd8) begin
                    exp_err++;
                end else if (dp == udp_rx_port_filter) begin
                    exp_start = 1;
                    pay   = int'(len) - 8;
                    avail = n - 8;
                    fwd   = (avail < pay) ? avail : pay;
                    if (avail < pay) exp_err++;
                end
            end
        end
        check_output({tag, "_starts"}, mon_starts - base_s, exp_start);
        check_output({tag, "_errs"}, mon_errs - base_e, exp_err);
        check_output({tag, "_count"}, mon_bytes.size() - base_b, fwd);
        if (exp_start == 1) begin
            check_output({tag, "_src_ip"}, mon_src_ip, ip);
            check_output({tag, "_src_port"}, {16'd0, mon_src_port}, {16'd0, sp});
            check_output({tag, "_dst_port"}, {16'd0, mon_dst_port}, {16'd0, dp});
            check_output({tag, "_data_len"}, {16'd0, mon_len}, {16'd0, len - 16'd8});
            check_output({tag, "_start_lat"}, last_start_cyc, tx_cycs[7] + 1);
        end
        for (int k = 0; k < fwd && (base_b + k) < mon_bytes.size(); k++) begin
            check_output($sformatf("%s_byte%0d", tag, k), {24'd0, mon_bytes[base_b + k]}, {24'd0, tx_bytes[8 + k]});
            check_output($sformatf("%s_last%0d", tag, k), {31'd0, mon_lasts[base_b + k]}, {31'd0, k == fwd - 1});
            check_output($sformatf("%s_lat%0d", tag, k), mon_cycs[base_b + k], tx_cycs[8 + k] + 1);
        end
    endtask

    initial begin
        int          base_s, base_e, base_b;
        int          kind, pay, n, gap;
        logic [7:0]  proto;
        logic        ip_ok;
        logic [31:0] ip;
        logic [15:0] sp, dp, len, cs;
        logic [7:0]  full[$];

        reset               = 1'b0;
        ip_rx_start         = 1'b0;
        ip_rx_protocol      = 8'h00;
        ip_rx_src_ip        = 32'h0;
        ip_rx_is_valid      = 1'b0;
        ip_rx_data_in       = 8'h00;
        ip_rx_data_in_valid = 1'b0;
        ip_rx_data_in_last  = 1'b0;
        udp_rx_port_filter  = 16'h0050;

        repeat (3) @(negedge clk);
        check_output("rst_start", {31'd0, udp_rx_start}, 32'd0);
        check_output("rst_valid", {31'd0, udp_rx_data_out_valid}, 32'd0);
        check_output("rst_err", {31'd0, udp_rx_err}, 32'd0);
        check_output("rst_src_ip", udp_rx_src_ip, 32'd0);
        check_output("rst_len", {16'd0, udp_rx_data_length}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] nominal datagram");
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        push_hdr(16'h1234, 16'h0050, 16'h000C, 16'h0000);
        tx_bytes.push_back(8'hDE); tx_bytes.push_back(8'hAD);
        tx_bytes.push_back(8'hBE); tx_bytes.push_back(8'hEF);
        apply_stimulus(8'h11, 1'b1, 32'hC0A8_0001, 1'b1, 0);
        check_datagram("nominal", 8'h11, 1'b1, 32'hC0A8_0001, base_s, base_e, base_b, 0);
        check_output("nominal_len_const", {16'd0, udp_rx_data_length}, 32'd4);

        $display("[TB] non-UDP datagram");
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        for (int i = 0; i < 20; i++) tx_bytes.push_back(8'(i + 1));
        apply_stimulus(8'h06, 1'b1, 32'h0A00_0002, 1'b1, 0);
        check_datagram("non_udp", 8'h06, 1'b1, 32'h0A00_0002, base_s, base_e, base_b, 0);

        $display("[TB] padding, then a normal datagram");
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        push_hdr(16'h0101, 16'h0050, 16'h000A, 16'hBEEF);
        for (int i = 0; i < 6; i++) tx_bytes.push_back(8'(8'hA0 + i));
        apply_stimulus(8'h11, 1'b1, 32'h0A00_0003, 1'b1, 0);
        check_datagram("padding", 8'h11, 1'b1, 32'h0A00_0003, base_s, base_e, base_b, 0);
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        push_hdr(16'h0202, 16'h0050, 16'h000B, 16'h0000);
        tx_bytes.push_back(8'h11); tx_bytes.push_back(8'h22); tx_bytes.push_back(8'h33);
        apply_stimulus(8'h11, 1'b1, 32'h0A00_0004, 1'b1, 0);
        check_datagram("after_pad", 8'h11, 1'b1, 32'h0A00_0004, base_s, base_e, base_b, 0);

        $display("[TB] truncated payload");
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        push_hdr(16'h0303, 16'h0050, 16'h0010, 16'h0000);
        tx_bytes.push_back(8'h5A); tx_bytes.push_back(8'h5B); tx_bytes.push_back(8'h5C);
        apply_stimulus(8'h11, 1'b1, 32'h0A00_0005, 1'b1, 0);
        check_datagram("trunc", 8'h11, 1'b1, 32'h0A00_0005, base_s, base_e, base_b, 0);

        $display("[TB] malformed headers");
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        push_hdr(16'h0404, 16'h0050, 16'h0004, 16'h0000);
        tx_bytes.push_back(8'h77);
        apply_stimulus(8'h11, 1'b1, 32'h0A00_0006, 1'b1, 0);
        check_datagram("short_len", 8'h11, 1'b1, 32'h0A00_0006, base_s, base_e, base_b, 0);
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        for (int i = 0; i < 5; i++) tx_bytes.push_back(8'(i));
        apply_stimulus(8'h11, 1'b1, 32'h0A00_0007, 1'b1, 0);
        check_datagram("hdr_cut", 8'h11, 1'b1, 32'h0A00_0007, base_s, base_e, base_b, 0);

        $display("[TB] port filter");
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        push_hdr(16'h0505, 16'h0051, 16'h000A, 16'h0000);
        tx_bytes.push_back(8'h01); tx_bytes.push_back(8'h02);
        apply_stimulus(8'h11, 1'b1, 32'h0A00_0008, 1'b1, 0);
        check_datagram("filter_drop", 8'h11, 1'b1, 32'h0A00_0008, base_s, base_e, base_b, 0);

        $display("[TB] new start abandons a header");
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        tx_bytes.delete();
        push_hdr(16'h0606, 16'h0050, 16'h000C, 16'h0000);
        void'(tx_bytes.pop_back()); void'(tx_bytes.pop_back());
        void'(tx_bytes.pop_back()); void'(tx_bytes.pop_back());
        apply_stimulus(8'h11, 1'b1, 32'h0A00_0009, 1'b0, 0);
        tx_bytes.delete();
        push_hdr(16'h0707, 16'h0050, 16'h0009, 16'h0000);
        tx_bytes.push_back(8'h99);
        apply_stimulus(8'h11, 1'b1, 32'h0A00_000A, 1'b1, 0);
        check_datagram("abandon", 8'h11, 1'b1, 32'h0A00_000A, base_s, base_e, base_b, 1);

        $display("[TB] reset in the middle of a payload");
        tx_bytes.delete();
        push_hdr(16'h0808, 16'h0050, 16'h0014, 16'h0000);
        for (int i = 0; i < 3; i++) tx_bytes.push_back(8'(8'hC0 + i));
        apply_stimulus(8'h11, 1'b1, 32'h0A00_000B, 1'b0, 0);
        ip_rx_data_in_valid = 1'b1;
        ip_rx_data_in       = 8'hC3;
        @(negedge clk);
        ip_rx_data_in_valid = 1'b0;
        check_output("pre_rst_valid", {31'd0, udp_rx_data_out_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check_output("mid_rst_valid", {31'd0, udp_rx_data_out_valid}, 32'd0);
        check_output("mid_rst_data", {24'd0, udp_rx_data_out}, 32'd0);
        check_output("mid_rst_src_port", {16'd0, udp_rx_src_port}, 32'd0);
        check_output("mid_rst_len", {16'd0, udp_rx_data_length}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
        for (int i = 0; i < 6; i++) begin
            ip_rx_data_in_valid = 1'b1;
            ip_rx_data_in       = 8'(i);
            ip_rx_data_in_last  = (i == 5);
            @(negedge clk);
        end
        ip_rx_data_in_valid = 1'b0;
        ip_rx_data_in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_output("post_rst_starts", mon_starts - base_s, 32'd0);
        check_output("post_rst_bytes", mon_bytes.size() - base_b, 32'd0);
        check_output("post_rst_errs", mon_errs - base_e, 32'd0);
        tx_bytes.delete();
        push_hdr(16'h0909, 16'h0050, 16'h000A, 16'h0000);
        tx_bytes.push_back(8'hE1); tx_bytes.push_back(8'hE2);
        apply_stimulus(8'h11, 1'b1, 32'h0A00_000C, 1'b1, 0);
        check_datagram("post_rst", 8'h11, 1'b1, 32'h0A00_000C, base_s, base_e, base_b, 0);

        $display("[TB] randomized datagrams");
        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(9);
            proto = (kind == 0) ? 8'h06 : 8'h11;
            ip_ok = (kind == 1) ? 1'b0 : 1'b1;
            ip    = $urandom;
            sp    = 16'($urandom);
            dp    = ($urandom_range(3) == 0) ? 16'($urandom) : 16'h0050;
            cs    = 16'($urandom);
            pay   = $urandom_range(12);
            len   = (kind == 2) ? 16'($urandom_range(7)) : 16'(8 + pay);
            tx_bytes.delete();
            push_hdr(sp, dp, len, cs);
            for (int i = 0; i < pay + 3; i++) tx_bytes.push_back(8'($urandom));
            full = tx_bytes;
            if (kind <= 1)      n = $urandom_range(1, full.size());
            else if (kind == 2) n = 8 + $urandom_range(3);
            else if (kind == 3) n = $urandom_range(1, 7 + pay);
            else                n = 8 + pay + $urandom_range(3);
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(full[i]);
            gap = ($urandom_range(1) == 0) ? 0 : 30;
            base_s = mon_starts; base_e = mon_errs; base_b = mon_bytes.size();
            apply_stimulus(proto, ip_ok, ip, 1'b1, gap);
            check_datagram($sformatf("rnd%0d", t), proto, ip_ok, ip, base_s, base_e, base_b, 0);
        end

        check_output("no_start_overlap", mon_overlap, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
